// File: rtl/reaction_time_display.sv
// Reaction-time display: binary ms -> BCD by sequential double dabble, then a multiplexed
// SS.mmm scan of the 8-digit active-low display. Optional feature macro: LEADING_ZERO_BLANK_EN.
module reaction_time_display #(
    parameter int REFRESH_BITS = 20,
    parameter int VAL_W        = 17,
    parameter int MAX_VAL      = 99999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VAL_W-1:0] val_in,
    input  logic             val_load,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             ovf,
    output logic [6:0]       SEG,
    output logic             DP,
    output logic [7:0]       AN
);
    localparam int         BIN_W     = 17;
    localparam int         NDIG      = 5;
    localparam int         SR_W      = BIN_W + 4 * NDIG;
    localparam logic [4:0] LAST_ITER = 5'(BIN_W - 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_LZ = 1'b1;
`else
    localparam bit BLANK_LZ = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t           state, state_nxt;
    logic [4:0]       iter;
    logic             pending;
    logic [BIN_W-1:0] pend_val;
    logic             pend_ovf;
    logic [BIN_W-1:0] cap_val;
    logic             cap_ovf;
    logic             conv_ovf;
    logic [SR_W-1:0]  shreg;
    logic [3:0]       digit [NDIG];

    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [2:0]              idx;
    logic [3:0]              cur_digit;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic [7:0]              an_nxt;

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int i = 0; i < NDIG; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5)
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        cap_ovf = (val_in > VAL_W'(MAX_VAL));
        cap_val = cap_ovf ? BIN_W'(MAX_VAL) : val_in[BIN_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (val_load || pending) state_nxt = SHIFT;
            SHIFT:   if (iter == LAST_ITER) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            iter    <= '0;
            pending <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            // NOTE: the digit array is reset because it is displayed straight out of reset.
            for (int i = 0; i < NDIG; i++) digit[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    iter    <= '0;
                    busy    <= val_load || pending;
                    pending <= 1'b0;
                end
                SHIFT: begin
                    iter <= iter + 5'd1;
                    busy <= 1'b1;
                    if (val_load) pending <= 1'b1;
                end
                COMMIT: begin
                    for (int i = 0; i < NDIG; i++) digit[i] <= shreg[BIN_W + 4*i +: 4];
                    ovf  <= conv_ovf;
                    busy <= 1'b1;
                    if (val_load) pending <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Payload only; state and pending qualify it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && (val_load || pending)) begin
            shreg    <= {{(4*NDIG){1'b0}}, (val_load ? cap_val : pend_val)};
            conv_ovf <= val_load ? cap_ovf : pend_ovf;
        end else if (state == SHIFT) begin
            shreg <= dabble_step(shreg);
        end
        if (state != IDLE && val_load) begin
            pend_val <= cap_val;
            pend_ovf <= cap_ovf;
        end
    end

    assign idx = scan_cnt[REFRESH_BITS-1 -: 3];

    always_comb begin
        an_nxt    = 8'hFF;
        seg_nxt   = 7'h7F;
        dp_nxt    = 1'b1;
        cur_digit = 4'd0;
        case (idx)
            3'd0:    cur_digit = digit[0];
            3'd1:    cur_digit = digit[1];
            3'd2:    cur_digit = digit[2];
            3'd3:    cur_digit = digit[3];
            3'd4:    cur_digit = digit[4];
            default: cur_digit = 4'd0;
        endcase
        if (idx <= 3'd4) begin
            an_nxt = ~(8'b1 << idx);
            case (mode)
                2'b00: begin
                    seg_nxt = seg_code(cur_digit);
                    dp_nxt  = (idx != 3'd3);
                    // Tens of seconds may blank; seconds stay lit so 0.xxx reads cleanly.
                    if (BLANK_LZ && idx == 3'd4 && cur_digit == 4'd0) seg_nxt = 7'h7F;
                end
                2'b10: begin
                    seg_nxt = 7'h00;
                    dp_nxt  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            SEG      <= 7'h7F;
            DP       <= 1'b1;
            AN       <= 8'hFF;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            SEG      <= seg_nxt;
            DP       <= dp_nxt;
            AN       <= an_nxt;
        end
    end

endmodule

// File: tb/tb_reaction_time_display.sv
// Self-checking bench for reaction_time_display: randomized loads against a decimal
// arithmetic model of the displayed digits, run with a short scan period.
module tb_reaction_time_display;
    localparam int RB   = 6;
    localparam int VW   = 17;
    localparam int MAXV = 99999;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] val_in = '0;
    logic          val_load = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          busy, ovf, DP;
    logic [6:0]    SEG;
    logic [7:0]    AN;

    int         checks = 0;
    int         failures = 0;
    int         errs, bn;
    logic [5:0] seen;

    reaction_time_display #(.REFRESH_BITS(RB), .VAL_W(VW), .MAX_VAL(MAXV)) dut (
        .clk(clk), .rst_n(rst_n), .val_in(val_in), .val_load(val_load), .mode(mode),
        .busy(busy), .ovf(ovf), .SEG(SEG), .DP(DP), .AN(AN)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] code_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Model: what SEG/DP must be for the digit enable pattern currently shown.
    // pos: -1 blank slot, 0..4 digit position, -2 illegal enable pattern.
    function automatic void exp_for_an(input int v, input logic [1:0] m, input logic [7:0] an,
                                       output logic [6:0] s, output logic d, output int pos);
        int x;
        s   = 7'h7F;
        d   = 1'b1;
        pos = (an == 8'hFF) ? -1 : -2;
        for (int k = 0; k < 5; k++) if (an == ~(8'(1) << k)) pos = k;
        if (pos >= 0) begin
            x = (v > MAXV) ? MAXV : v;
            for (int k = 0; k < pos; k++) x = x / 10;
            x = x % 10;
            case (m)
                2'b00: begin
                    s = code_of(x);
                    d = (pos == 3) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                    if (pos == 4 && x == 0) s = 7'h7F;
`endif
                end
                2'b10: begin s = 7'h00; d = 1'b0; end
                default: ;
            endcase
        end
    endfunction

    task automatic observe_scan(input int v, input logic [1:0] m, output int e, output logic [5:0] sn);
        logic [6:0] es;
        logic       ed;
        int         p;
        e  = 0;
        sn = '0;
        for (int n = 0; n < 72; n++) begin
            @(negedge clk);
            exp_for_an(v, m, AN, es, ed, p);
            if (p == -2 || SEG !== es || DP !== ed) begin
                e++;
                if (e <= 3) $display("  scan detail: AN=%h SEG=%h DP=%b, model SEG=%h DP=%b", AN, SEG, DP, es, ed);
            end
            if (p == -1) sn[5] = 1'b1;
            else if (p >= 0) sn[p] = 1'b1;
        end
    endtask

    task automatic load_and_count(input int v1, input int j, input int v2, output int busy_n);
        @(negedge clk);
        val_in   = VW'(v1);
        val_load = 1'b1;
        busy_n   = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            val_load = (j != 0 && n == j);
            if (j != 0 && n == j) val_in = VW'(v2);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_flags: busy=%b ovf=%b, required 0 0", busy, ovf); end
        checks++; if (SEG !== 7'h7F || DP !== 1'b1 || AN !== 8'hFF) begin failures++; $display("FAIL reset_display: SEG=%h DP=%b AN=%h, required 7f 1 ff", SEG, DP, AN); end
        rst_n = 1'b1;
        @(negedge clk);
        val_in = VW'(777); val_load = 1'b1;
        @(negedge clk);
        val_load = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_pre_busy: busy=%b, required 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_mid_flags: busy=%b ovf=%b, required 0 0", busy, ovf); end
        checks++; if (SEG !== 7'h7F || DP !== 1'b1 || AN !== 8'hFF) begin failures++; $display("FAIL reset_mid_display: SEG=%h DP=%b AN=%h, required 7f 1 ff", SEG, DP, AN); end
        @(negedge clk);
        rst_n = 1'b1;
        observe_scan(0, 2'b00, errs, seen);
        checks++; if (errs != 0) begin failures++; $display("FAIL reset_scan: %0d bad samples, required 0", errs); end
        checks++; if (seen !== 6'h3F) begin failures++; $display("FAIL reset_cover: seen=%b, required 111111", seen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_resume: busy=%b, required 0", busy); end
    endtask

    task automatic test_single;
        mode = 2'b00;
        load_and_count(1234, 0, 0, bn);
        checks++; if (bn != 19) begin failures++; $display("FAIL single_busy_len: %0d cycles, required 19", bn); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL single_ovf: ovf=%b, required 0", ovf); end
        observe_scan(1234, 2'b00, errs, seen);
        checks++; if (errs != 0) begin failures++; $display("FAIL single_scan: %0d bad samples, required 0", errs); end
        checks++; if (seen !== 6'h3F) begin failures++; $display("FAIL single_cover: seen=%b, required 111111", seen); end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        val_in = VW'(120000); val_load = 1'b1;
        bn = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            val_load = 1'b0;
            if (busy === 1'b1) bn++;
            if (n == 18) begin
                checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf_early: ovf=%b at cycle 18, required 0", ovf); end
            end
            if (n == 19) begin
                checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf_commit: ovf=%b at cycle 19, required 1", ovf); end
            end
        end
        checks++; if (bn != 19) begin failures++; $display("FAIL sat_busy_len: %0d cycles, required 19", bn); end
        observe_scan(120000, 2'b00, errs, seen);
        checks++; if (errs != 0) begin failures++; $display("FAIL sat_scan: %0d bad samples, required 0", errs); end
        load_and_count(5, 0, 0, bn);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf_clear: ovf=%b, required 0", ovf); end
        observe_scan(5, 2'b00, errs, seen);
        checks++; if (errs != 0) begin failures++; $display("FAIL sat_after_scan: %0d bad samples, required 0", errs); end
    endtask

    task automatic test_modes;
        logic [1:0] mlist [4];
        mlist = '{2'b10, 2'b01, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin
            mode = mlist[i];
            observe_scan(5, mlist[i], errs, seen);
            checks++; if (errs != 0) begin failures++; $display("FAIL mode_scan: mode=%b %0d bad samples, required 0", mlist[i], errs); end
            checks++; if (seen !== 6'h3F) begin failures++; $display("FAIL mode_cover: mode=%b seen=%b, required 111111", mlist[i], seen); end
        end
    endtask

    task automatic test_boundary;
        load_and_count(0, 0, 0, bn);
        observe_scan(0, 2'b00, errs, seen);
        checks++; if (errs != 0) begin failures++; $display("FAIL zero_scan: %0d bad samples, required 0", errs); end
        load_and_count(99999, 0, 0, bn);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL max_ovf: ovf=%b, required 0", ovf); end
        observe_scan(99999, 2'b00, errs, seen);
        checks++; if (errs != 0) begin failures++; $display("FAIL max_scan: %0d bad samples, required 0", errs); end
    endtask

    task automatic test_back_to_back;
        int         guard;
        int         shown;
        int         p;
        logic [6:0] es;
        logic       ed;
        guard = 0;
        while (AN !== 8'hFF && guard < 200) begin @(negedge clk); guard++; end
        while (AN !== 8'hFE && guard < 400) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 400) begin
            failures++; $display("FAIL b2b_sync: digit 0 enable not seen within %0d cycles", guard);
        end else begin
            val_in = VW'(500); val_load = 1'b1;
            for (int n = 1; n <= 46; n++) begin
                @(negedge clk);
                shown = (n >= 39) ? 7 : ((n >= 20) ? 500 : 99999);
                checks++; if (busy !== (n <= 38)) begin failures++; $display("FAIL b2b_busy: cycle %0d busy=%b, required %0d", n, busy, (n <= 38)); end
                checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf: cycle %0d ovf=%b, required 0", n, ovf); end
                exp_for_an(shown, 2'b00, AN, es, ed, p);
                checks++;
                if (p == -2 || SEG !== es || DP !== ed) begin
                    failures++;
                    $display("FAIL b2b_display: cycle %0d AN=%h SEG=%h DP=%b, required SEG=%h DP=%b (value %0d)", n, AN, SEG, DP, es, ed, shown);
                end
                val_load = (n == 3 || n == 10);
                if (n == 3) val_in = VW'(42);
                if (n == 10) val_in = VW'(7);
            end
            observe_scan(7, 2'b00, errs, seen);
            checks++; if (errs != 0) begin failures++; $display("FAIL b2b_final_scan: %0d bad samples, required 0", errs); end
        end
    endtask

    task automatic test_random;
        int         v1, v2, j, fin;
        bit         two;
        logic [1:0] m;
        for (int it = 0; it < 8; it++) begin
            v1  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAXV)) : int'($urandom_range(95000, 131071));
            two = ($urandom_range(0, 2) == 0);
            j   = two ? int'($urandom_range(1, 18)) : 0;
            v2  = int'($urandom_range(0, 131071));
            m   = 2'($urandom_range(0, 3));
            fin = two ? v2 : v1;
            mode = m;
            load_and_count(v1, j, v2, bn);
            checks++; if (bn != (two ? 38 : 19)) begin failures++; $display("FAIL rand_busy_len: %0d cycles, required %0d", bn, (two ? 38 : 19)); end
            checks++; if (ovf !== (fin > MAXV)) begin failures++; $display("FAIL rand_ovf: value %0d ovf=%b, required %0d", fin, ovf, (fin > MAXV)); end
            observe_scan(fin, m, errs, seen);
            checks++; if (errs != 0) begin failures++; $display("FAIL rand_scan: value %0d mode=%b %0d bad samples, required 0", fin, m, errs); end
        end
        mode = 2'b00;
    endtask

    initial begin
        test_reset;
        test_single;
        test_saturation;
        test_modes;
        test_boundary;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
